hilo_multu: RTL
===============

# hilo_multu

Sequential 32×32 unsigned shift-add multiplier with its own HI/LO result registers. It is driven by the same operand buses (dataA, dataB) and 6-bit function code (Signal) as the ALU, and sits beside it in the datapath. It consumes MULTU, MFHI and MFLO codes and produces the HI/LO readout on its own dataOut. The top-level result mux selects this dataOut for MFHI/MFLO.

## Interface
- WIDTH, 32: operand width; HI and LO are WIDTH bits each.
- MULTU_CODE, 6'd25: Signal value that starts a multiply.
- MFHI_CODE, 6'd16: Signal value that reads HI.
- MFLO_CODE, 6'd18: Signal value that reads LO.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-low reset.
- dataA  input  WIDTH  multiplicand; sampled only on acceptance.
- dataB  input  WIDTH  multiplier; sampled only on acceptance.
- Signal  input  6  function code.
- dataOut  output  WIDTH  HI when Signal==MFHI_CODE, LO when Signal==MFLO_CODE, else 0. Combinational from the registers.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when HI/LO have just been updated.

## Operation
- States: IDLE, MUL, DONE.
- Internal registers:
  - mcand: WIDTH bits.
  - prod: 2·WIDTH bits.
  - cnt: clog2(WIDTH) bits.
  - hi, lo: WIDTH bits each.
- Acceptance occurs in IDLE or DONE when Signal==MULTU_CODE at a rising edge:
  - mcand ← dataA.
  - prod ← {WIDTH'b0, dataB}.
  - cnt ← 0.
  - Next state is MUL.
- Each MUL edge does one iteration:
  - sum[WIDTH:0] = prod[0] ? prod[2W-1:W] + mcand : {1'b0, prod[2W-1:W]}. The sum is WIDTH+1 bits and the carry is kept.
  - prod ← {sum, prod[W-1:1]}.
  - cnt ← cnt+1.
- The iteration with cnt==WIDTH-1 is the last one:
  - The same edge writes {hi, lo} ← final prod value.
  - Next state is DONE.
- DONE:
  - done=1.
  - Next state is IDLE unless a new MULTU is accepted in that cycle.
- MULTU while in MUL is ignored: no restart and no queuing.
- Operand changes after acceptance have no effect.
- hi and lo change only on the final-iteration edge. MFHI/MFLO during MUL return the previous result.
- dataOut decodes Signal combinationally. Any other code gives 0.
- Result is exact unsigned: {hi, lo} = dataA × dataB mod 2^(2·WIDTH). No overflow is possible.

## Timing
- Reset (reset=0, asynchronous):
  - state=IDLE, hi=0, lo=0, prod=0, mcand=0, cnt=0.
  - busy=0, done=0, dataOut=0.
  - Takes effect immediately, without waiting for a clock edge.
- Reset asserted mid-operation aborts the multiply. HI/LO return to 0 and the partial result is discarded.
- Latency:
  - MULTU sampled at edge E0.
  - busy=1 for the WIDTH cycles following E0.
  - hi/lo are written at edge E0+WIDTH.
  - done=1 for the cycle after E0+WIDTH, i.e. WIDTH+1 cycles after acceptance (33 for WIDTH=32).
- busy and done are Moore outputs and are never both high.
- Back-to-back: MULTU presented during the DONE cycle is accepted at the edge ending DONE. The next busy period starts with no IDLE gap, and the prior result is already visible on MFHI/MFLO.
- Simultaneous final-iteration write and MFHI/MFLO:
  - In the cycle before the write edge, the old value is read.
  - In the DONE cycle, the new value is read.
- Signal=MULTU held continuously restarts a new multiply in every DONE cycle.

## Test plan
- Reset: assert reset=0 mid-cycle with no clock edge → busy=0, done=0. Afterwards MFHI and MFLO both read 32'h0.
- Basic multiply: MULTU with A=3, B=5 → busy for 32 cycles, then done pulses 33 cycles after acceptance. MFLO=32'd15 and MFHI=0.
- Max operands: A=B=32'hFFFFFFFF → HI=32'hFFFFFFFE, LO=32'h00000001. This exercises the carry bit.
- Busy interlock:
  - Start A=32'h00010000, B=32'h00010000.
  - While busy, issue MULTU with A=7, B=9 and change dataA/dataB.
  - Required: HI=1, LO=0; the second MULTU is ignored.
  - MFLO mid-run returns the previous result.
- Reset mid-operation: reset=0 at cycle 10 of a multiply → HI/LO=0, state IDLE, and no done pulse. A subsequent 6×7 gives LO=42.
- Back-to-back: 2×3, then 4×5 issued in the DONE cycle:
  - LO=6 readable in that DONE cycle.
  - Second done pulses exactly 33 cycles later with LO=20.

Source files
------------

// File: rtl/hilo_multu.sv
// hilo_multu: sequential unsigned shift-add multiplier with private HI/LO
// result registers. It sits beside the ALU, decodes the same function code,
// and returns HI or LO on its own read port.
//
// Ports:
//   clk     - rising-edge clock
//   reset   - asynchronous, active-low reset
//   dataA   - multiplicand, captured when a multiply is accepted
//   dataB   - multiplier, captured when a multiply is accepted
//   Signal  - 6-bit function code (MULTU starts, MFHI/MFLO read)
//   dataOut - HI on MFHI, LO on MFLO, otherwise zero (combinational)
//   busy    - high while iterating
//   done    - one-cycle pulse after HI/LO have been updated
module hilo_multu #(
  parameter int unsigned WIDTH      = 32,
  parameter logic [5:0]  MULTU_CODE = 6'd25,
  parameter logic [5:0]  MFHI_CODE  = 6'd16,
  parameter logic [5:0]  MFLO_CODE  = 6'd18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done
);

  localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH:0]     sum;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               accept;
  logic               last;

  // One shift-add step; the carry out of the upper half is kept so the
  // shifted product stays exact.
  always_comb begin
    sum = {1'b0, prod[2*WIDTH-1:WIDTH]};
    if (prod[0]) begin
      sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    end
    prod_next = {sum, prod[WIDTH-1:1]};
  end

  always_comb begin
    accept     = ((state == S_IDLE) || (state == S_DONE)) && (Signal == MULTU_CODE);
    last       = (state == S_MUL) && (cnt == LAST);
    busy       = (state == S_MUL);
    done       = (state == S_DONE);
    next_state = state;
    case (state)
      S_IDLE:  if (accept) next_state = S_MUL;
      S_MUL:   if (last) next_state = S_DONE;
      S_DONE:  next_state = accept ? S_MUL : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand <= '0;
      prod  <= '0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (accept) begin
      mcand <= dataA;
      prod  <= {{WIDTH{1'b0}}, dataB};
      cnt   <= '0;
    end else if (state == S_MUL) begin
      prod <= prod_next;
      cnt  <= cnt + CW'(1);
      // HI/LO take the finished product on the same edge as the last step,
      // so they are never exposed to partial results.
      if (last) begin
        {hi, lo} <= prod_next;
      end
    end
  end

  always_comb begin
    dataOut = '0;
    if (Signal == MFHI_CODE) begin
      dataOut = hi;
    end else if (Signal == MFLO_CODE) begin
      dataOut = lo;
    end
  end

endmodule
